// File: rtl/alu_issue_seq.sv
// alu_issue_seq: in-order instruction issue to the byte ALU with credit-gated result capture.
// Optional illegal-opcode filtering (0xC-0xE dropped, sticky flag) is enabled by ALU_SEQ_ILLEGAL_CHK_EN.
module alu_issue_seq #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_instr,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_data,
  input  logic [7:0]  alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic        illegal
);
  localparam int AW = $clog2(DEPTH);

  logic [12:0] instr_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [12:0] head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        issue;
  logic        head_drop;
  logic        credit_ok;
  logic [2:0]  credit_used;
  logic        cap_vld_p1;
  logic        cap_vld_p2;
  logic [7:0]  res_mem [2];
  logic        res_wr;
  logic        res_rd;
  logic [1:0]  res_cnt;
  logic        res_push;
  logic        res_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = ~fifo_full;
  assign push       = in_valid & ~fifo_full;
  assign head       = instr_mem[rd_ptr[AW-1:0]];

  // Held results plus captures still travelling down the pipe must leave room in the 2-entry FIFO.
  assign credit_used = {1'b0, res_cnt} + {2'b00, cap_vld_p1} + {2'b00, cap_vld_p2};
  assign credit_ok   = (credit_used < 3'd2);

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  logic illegal_q;

  assign head_drop = ~fifo_empty && (head[11:8] >= 4'hC) && (head[11:8] <= 4'hE);
  assign illegal   = illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (pop && head_drop) begin
      illegal_q <= 1'b1;
    end
  end
`else
  assign head_drop = 1'b0;
  assign illegal   = 1'b0;
`endif

  // Dropped instructions bypass the credit check since they never capture.
  assign pop   = ~fifo_empty & (head_drop | ~head[12] | credit_ok);
  assign issue = pop & ~head_drop;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr[AW-1:0]] <= in_instr;
    end
  end

  // Stage p1: issue register and capture flag load together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      alu_opcode <= 4'h0;
      alu_data   <= 8'h00;
      cap_vld_p1 <= 1'b0;
      cap_vld_p2 <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      alu_opcode <= issue ? head[11:8] : 4'h0;
      alu_data   <= issue ? head[7:0]  : 8'h00;
      cap_vld_p1 <= issue & head[12];
      // Stage p2: ALU has sampled; its data_out is valid for capture on the next edge
      cap_vld_p2 <= cap_vld_p1;
    end
  end

  assign res_push  = cap_vld_p2;
  assign res_valid = (res_cnt != 2'd0);
  assign res_pop   = res_valid & res_ready;
  assign res_data  = res_mem[res_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_mem[0] <= 8'h00;
      res_mem[1] <= 8'h00;
      res_wr     <= 1'b0;
      res_rd     <= 1'b0;
      res_cnt    <= 2'd0;
    end else begin
      if (res_push) begin
        res_mem[res_wr] <= alu_result;
        res_wr          <= ~res_wr;
      end
      if (res_pop) res_rd <= ~res_rd;
      res_cnt <= res_cnt + {1'b0, res_push} - {1'b0, res_pop};
    end
  end

  assign busy = ~fifo_empty | (alu_opcode != 4'h0) | (alu_data != 8'h00) | cap_vld_p1 | cap_vld_p2;

endmodule
